mem_port_arbiter: RTL and testbench

- Shares one memory port between two requesters: the icache refill port (read-only) and the processor data port (read/write, byte strobes).
- Lets one unified memory replace the split imem/dmem pair behind picorv32 + icache_1wa.
- Downstream side uses the same valid/ready/addr/wdata/wstrb/rdata protocol as the memories.
- Grants one transaction at a time and holds the grant until the downstream handshake completes.

---
 rtl/mem_port_arb_pkg.sv | 21 ++
 rtl/mem_port_arb_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_port_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   localparam int PRIO_RR   = 0;
   localparam int PRIO_DATA = 1;

   // Round-robin choice: hand the port to whoever did not have it last.
   function automatic logic rr_other(input logic last_id);
      return (last_id == REQ_D) ? REQ_I : REQ_D;
   endfunction

endpackage

// File: rtl/mem_port_arb_pick.sv
// Combinational grant picker for the icache / data requesters.
module mem_port_arb_pick
   import mem_port_arb_pkg::*;
#(
   parameter int PRIORITY = PRIO_RR
) (
   input  logic i_valid,
   input  logic d_valid,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = i_valid | d_valid;
      grant_id    = REQ_I;
      if (i_valid && d_valid) begin
         if (PRIORITY == PRIO_DATA) grant_id = REQ_D;
         else                       grant_id = rr_other(last_grant);
      end else if (d_valid) begin
         grant_id = REQ_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between icache refill and data.
// Optional grant/conflict counters enabled by MEM_PORT_ARB_STATS_EN.
//
// state  | meaning
// IDLE   | no owner; sample requests, register grant
// BUSY_I | icache refill owns the port until handshake or valid drop
// BUSY_D | data port owns the port until handshake or valid drop
module mem_port_arbiter
   import mem_port_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int PRIORITY = PRIO_RR
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                i_valid,
   output logic                i_ready,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_valid,
   output logic                d_ready,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_PORT_ARB_STATS_EN
   ,
   output logic [31:0]         stat_i_grants,
   output logic [31:0]         stat_d_grants,
   output logic [31:0]         stat_conflicts
`endif
);

   arb_state_e state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       grant_valid, grant_id;

   mem_port_arb_pick #(.PRIORITY(PRIORITY)) u_pick (
      .i_valid     (i_valid),
      .d_valid     (d_valid),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_D;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Owner dropping valid ends the tenure without a ready.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_valid    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_wstrb    = '0;
      i_ready      = 1'b0;
      d_ready      = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d      = (grant_id == REQ_D) ? BUSY_D : BUSY_I;
               last_grant_d = grant_id;
            end
         end
         BUSY_I: begin
            mem_valid = i_valid;
            mem_addr  = i_addr;
            if (!i_valid) begin
               state_d = IDLE;
            end else if (mem_ready) begin
               i_ready = 1'b1;
               state_d = IDLE;
            end
         end
         BUSY_D: begin
            mem_valid = d_valid;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
            if (!d_valid) begin
               state_d = IDLE;
            end else if (mem_ready) begin
               d_ready = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

`ifdef MEM_PORT_ARB_STATS_EN
   logic [31:0] stat_i_q, stat_i_d;
   logic [31:0] stat_d_q, stat_d_d;
   logic [31:0] stat_c_q, stat_c_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_i_q <= '0;
         stat_d_q <= '0;
         stat_c_q <= '0;
      end else begin
         stat_i_q <= stat_i_d;
         stat_d_q <= stat_d_d;
         stat_c_q <= stat_c_d;
      end
   end

   always_comb begin
      stat_i_d = stat_i_q;
      stat_d_d = stat_d_q;
      stat_c_d = stat_c_q;
      if (state_q == IDLE) begin
         if (grant_valid && grant_id == REQ_I) stat_i_d = stat_i_q + 32'd1;
         if (grant_valid && grant_id == REQ_D) stat_d_d = stat_d_q + 32'd1;
         if (i_valid && d_valid)               stat_c_d = stat_c_q + 32'd1;
      end
   end

   assign stat_i_grants  = stat_i_q;
   assign stat_d_grants  = stat_d_q;
   assign stat_conflicts = stat_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin and a data-priority arbiter share one stimulus stream.
module tb_mem_port_arbiter;

   localparam logic [31:0] I_ADDR  = 32'h0000_0100;
   localparam logic [31:0] D_ADDR  = 32'h0000_2000;
   localparam logic [31:0] D_WDATA = 32'h1234_5678;
   localparam logic [3:0]  D_WSTRB = 4'b0011;
   localparam logic [31:0] M_RDATA = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        i_valid, d_valid, mem_ready;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_wstrb;

   logic        i_ready0, d_ready0, mem_valid0;
   logic [31:0] i_rdata0, d_rdata0, mem_addr0, mem_wdata0;
   logic [3:0]  mem_wstrb0;
   logic        i_ready1, d_ready1, mem_valid1;
   logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
   logic [3:0]  mem_wstrb1;
`ifdef MEM_PORT_ARB_STATS_EN
   logic [31:0] si0, sd0, sc0, si1, sd1, sc1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIORITY(0)) dut_rr (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(i_ready0), .i_addr(i_addr), .i_rdata(i_rdata0),
      .d_valid(d_valid), .d_ready(d_ready0), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata0),
      .mem_valid(mem_valid0), .mem_ready(mem_ready), .mem_addr(mem_addr0),
      .mem_wdata(mem_wdata0), .mem_wstrb(mem_wstrb0), .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARB_STATS_EN
      , .stat_i_grants(si0), .stat_d_grants(sd0), .stat_conflicts(sc0)
`endif
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIORITY(1)) dut_pr (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(i_ready1), .i_addr(i_addr), .i_rdata(i_rdata1),
      .d_valid(d_valid), .d_ready(d_ready1), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata1),
      .mem_valid(mem_valid1), .mem_ready(mem_ready), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1), .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARB_STATS_EN
      , .stat_i_grants(si1), .stat_d_grants(sd1), .stat_conflicts(sc1)
`endif
   );

   // o0/o1: expected port owner seen on mem_* (0 none, 1 icache, 2 data)
   typedef struct {
      logic       iv;
      logic       dv;
      logic       mr;
      logic [1:0] o0;
      logic [1:0] o1;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(logic iv, logic dv, logic mr, logic [1:0] o0, logic [1:0] o1);
      vec_t v;
      v.iv = iv; v.dv = dv; v.mr = mr; v.o0 = o0; v.o1 = o1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_dut(input string tag, input logic [1:0] o, input logic mr,
                          input logic mv, input logic ir, input logic dr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] ird,
                          input logic [31:0] drd);
      chk({tag, " mem_valid"}, {31'd0, mv}, {31'd0, o != 2'd0});
      chk({tag, " i_ready"}, {31'd0, ir}, {31'd0, (o == 2'd1) && mr});
      chk({tag, " d_ready"}, {31'd0, dr}, {31'd0, (o == 2'd2) && mr});
      if (o == 2'd1) begin
         chk({tag, " mem_addr(I)"}, addr, I_ADDR);
         chk({tag, " mem_wdata(I)"}, wdata, 32'd0);
         chk({tag, " mem_wstrb(I)"}, {28'd0, wstrb}, 32'd0);
         if (mr) chk({tag, " i_rdata"}, ird, M_RDATA);
      end
      if (o == 2'd2) begin
         chk({tag, " mem_addr(D)"}, addr, D_ADDR);
         chk({tag, " mem_wdata(D)"}, wdata, D_WDATA);
         chk({tag, " mem_wstrb(D)"}, {28'd0, wstrb}, {28'd0, D_WSTRB});
         if (mr) chk({tag, " d_rdata"}, drd, M_RDATA);
      end
   endtask

   task automatic chk_both(input string tag, input logic [1:0] o0, input logic [1:0] o1);
      chk_dut({tag, " rr"}, o0, mem_ready, mem_valid0, i_ready0, d_ready0,
              mem_addr0, mem_wdata0, mem_wstrb0, i_rdata0, d_rdata0);
      chk_dut({tag, " pr"}, o1, mem_ready, mem_valid1, i_ready1, d_ready1,
              mem_addr1, mem_wdata1, mem_wstrb1, i_rdata1, d_rdata1);
   endtask

   initial begin
      // single icache refill, memory answers one cycle after mem_valid
      vecs[0]  = mk(1, 0, 0, 0, 0);
      vecs[1]  = mk(1, 0, 0, 1, 1);
      vecs[2]  = mk(1, 0, 1, 1, 1);
      vecs[3]  = mk(0, 0, 1, 0, 0);   // mem_ready while idle is ignored
      // data write
      vecs[4]  = mk(0, 1, 0, 0, 0);
      vecs[5]  = mk(0, 1, 0, 2, 2);
      vecs[6]  = mk(0, 1, 1, 2, 2);
      vecs[7]  = mk(0, 0, 0, 0, 0);
      // both held for four transactions: rr I,D,I,D ; priority D,D,D,D
      vecs[8]  = mk(1, 1, 0, 0, 0);
      vecs[9]  = mk(1, 1, 1, 1, 2);
      vecs[10] = mk(1, 1, 0, 0, 0);
      vecs[11] = mk(1, 1, 1, 2, 2);
      vecs[12] = mk(1, 1, 0, 0, 0);
      vecs[13] = mk(1, 1, 1, 1, 2);
      vecs[14] = mk(1, 1, 0, 0, 0);
      vecs[15] = mk(1, 1, 1, 2, 2);
      // d drops: icache finally granted on both
      vecs[16] = mk(1, 0, 0, 0, 0);
      vecs[17] = mk(1, 0, 0, 1, 1);
      // icache abandons before mem_ready; pending data granted after the bubble
      vecs[18] = mk(0, 1, 1, 0, 0);
      vecs[19] = mk(0, 1, 0, 0, 0);
      vecs[20] = mk(0, 1, 0, 2, 2);

      resetn    = 1'b0;
      i_valid   = 1'b1;
      d_valid   = 1'b1;
      mem_ready = 1'b1;
      i_addr    = I_ADDR;
      d_addr    = D_ADDR;
      d_wdata   = D_WDATA;
      d_wstrb   = D_WSTRB;
      mem_rdata = M_RDATA;
      repeat (2) @(negedge clk);
      #1;
      chk_both("reset", 2'd0, 2'd0);
`ifdef MEM_PORT_ARB_STATS_EN
      chk("reset stat_i rr", si0, 32'd0);
      chk("reset stat_c pr", sc1, 32'd0);
`endif
      i_valid   = 1'b0;
      d_valid   = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         i_valid   = vecs[k].iv;
         d_valid   = vecs[k].dv;
         mem_ready = vecs[k].mr;
         #1;
         chk_both($sformatf("row%0d", k), vecs[k].o0, vecs[k].o1);
      end

`ifdef MEM_PORT_ARB_STATS_EN
      chk("stat_i rr", si0, 32'd4);
      chk("stat_d rr", sd0, 32'd4);
      chk("stat_c rr", sc0, 32'd4);
      chk("stat_i pr", si1, 32'd2);
      chk("stat_d pr", sd1, 32'd6);
      chk("stat_c pr", sc1, 32'd4);
`endif

      // reset pulled during BUSY_D; memory answers on the next cycle
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk_both("async reset busy", 2'd0, 2'd0);
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk_both("late mem_ready in reset", 2'd0, 2'd0);
      @(negedge clk);
      resetn    = 1'b1;
      d_valid   = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk_both("after reset idle", 2'd0, 2'd0);
`ifdef MEM_PORT_ARB_STATS_EN
      chk("post-reset stat_i rr", si0, 32'd0);
      chk("post-reset stat_d rr", sd0, 32'd0);
      chk("post-reset stat_c rr", sc0, 32'd0);
      chk("post-reset stat_d pr", sd1, 32'd0);
`endif
      // tie after reset goes to icache again under round-robin
      @(negedge clk);
      i_valid   = 1'b1;
      d_valid   = 1'b1;
      mem_ready = 1'b0;
      #1;
      chk_both("post-reset tie idle", 2'd0, 2'd0);
      @(negedge clk);
      #1;
      chk_both("post-reset tie grant", 2'd1, 2'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
